// File: rtl/hold_mux_n.sv
// Priority-select N-channel mux with registered output, hold/clear on idle,
// sticky multi-select error flag and a saturating capture counter.
module hold_mux_n #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 3,
  parameter  int HOLD     = 1,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       sel,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      multi_err,
  output logic [CNT_W-1:0]          cap_cnt
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             multi_err_q, multi_err_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;

  logic             any_s;
  logic             multi_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [WIDTH-1:0] win_data_s;

  // Priority encode: scanning downward lets the lowest set select win.
  always_comb begin
    win_idx_s  = '0;
    win_data_s = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      win_idx_s  = sel[k] ? IDX_W'(k) : win_idx_s;
      win_data_s = sel[k] ? in_data[k*WIDTH +: WIDTH] : win_data_s;
    end
    any_s   = |sel;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_s = (sel & (sel - CHANNELS'(1))) != '0;
  end

  // Next-state for output data, index, valid, error flag and counter.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    multi_err_d = multi_err_q;
    cap_cnt_d   = cap_cnt_q;
    if (any_s) begin
      out_d       = win_data_s;
      out_idx_d   = win_idx_s;
      out_valid_d = 1'b1;
    end else if (HOLD == 0) begin
      out_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
    end
    if (any_s && (cap_cnt_q != {CNT_W{1'b1}})) begin
      cap_cnt_d = cap_cnt_q + CNT_W'(1);
    end else begin
      cap_cnt_d = cap_cnt_q;
    end
    // Set has priority over clear when both happen on one edge.
    if (multi_s) begin
      multi_err_d = 1'b1;
    end else if (clr_err) begin
      multi_err_d = 1'b0;
    end else begin
      multi_err_d = multi_err_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      multi_err_q <= 1'b0;
      cap_cnt_q   <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      multi_err_q <= multi_err_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign multi_err = multi_err_q;
  assign cap_cnt   = cap_cnt_q;

endmodule

// File: tb/tb_hold_mux_n.sv
// Scoreboard bench for hold_mux_n: three configurations driven in lockstep,
// expected state computed by a behavioural model and popped by a monitor.
module tb_hold_mux_n;

  typedef struct packed {
    logic [15:0] out;
    logic [2:0]  idx;
    logic        valid;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clr_err;
  logic [2:0]  sel3;
  logic [23:0] data3;
  logic [4:0]  sel5;
  logic [79:0] data5;

  logic [7:0]  o0;  logic v0; logic [1:0] i0; logic e0; logic [7:0] c0;
  logic [7:0]  o1;  logic v1; logic [1:0] i1; logic e1; logic [1:0] c1;
  logic [15:0] o2;  logic v2; logic [2:0] i2; logic e2; logic [7:0] c2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t m0, m1, m2;

  int checks = 0;
  int errors = 0;

  hold_mux_n #(.WIDTH(8), .CHANNELS(3), .HOLD(1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_data(data3), .sel(sel3), .clr_err(clr_err),
    .out(o0), .out_valid(v0), .out_idx(i0), .multi_err(e0), .cap_cnt(c0));

  hold_mux_n #(.WIDTH(8), .CHANNELS(3), .HOLD(0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_data(data3), .sel(sel3), .clr_err(clr_err),
    .out(o1), .out_valid(v1), .out_idx(i1), .multi_err(e1), .cap_cnt(c1));

  hold_mux_n #(.WIDTH(16), .CHANNELS(5), .HOLD(1), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .in_data(data5), .sel(sel5), .clr_err(clr_err),
    .out(o2), .out_valid(v2), .out_idx(i2), .multi_err(e2), .cap_cnt(c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lowest set select wins, idle either holds or clears, counter saturates.
  function automatic exp_t model_next(exp_t s, logic [4:0] sel, logic [79:0] data,
                                      int w, int nch, bit hold, int cmax, bit clr);
    exp_t r = s;
    int   win = -1;
    int   n = $countones(sel);
    logic [79:0] mask = (80'd1 << w) - 80'd1;
    for (int k = nch - 1; k >= 0; k--) if (sel[k]) win = k;
    if (win >= 0) begin
      r.out   = 16'((data >> (win * w)) & mask);
      r.idx   = 3'(win);
      r.valid = 1'b1;
      if (int'(s.cnt) < cmax) r.cnt = s.cnt + 8'd1;
    end else if (!hold) begin
      r.out   = 16'd0;
      r.valid = 1'b0;
    end
    if (n >= 2) r.err = 1'b1;
    else if (clr) r.err = 1'b0;
    return r;
  endfunction

  task automatic cmp_inst(input string tag, input exp_t a, input exp_t e);
    chk({tag, "_out"},   32'(a.out),   32'(e.out));
    chk({tag, "_idx"},   32'(a.idx),   32'(e.idx));
    chk({tag, "_valid"}, 32'(a.valid), 32'(e.valid));
    chk({tag, "_err"},   32'(a.err),   32'(e.err));
    chk({tag, "_cnt"},   32'(a.cnt),   32'(e.cnt));
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t a, e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {16'(o0), 3'(i0), v0, e0, 8'(c0)};
      cmp_inst("u0", a, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {16'(o1), 3'(i1), v1, e1, 8'(c1)};
      cmp_inst("u1", a, e);
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = {o2, i2, v2, e2, c2};
      cmp_inst("u2", a, e);
    end
  end

  task automatic step(input logic [2:0] s3, input logic [23:0] d3,
                      input logic [4:0] s5, input logic [79:0] d5, input logic c);
    sel3 = s3; data3 = d3; sel5 = s5; data5 = d5; clr_err = c;
    m0 = model_next(m0, {2'b00, s3}, {56'd0, d3}, 8, 3, 1'b1, 255, c);
    m1 = model_next(m1, {2'b00, s3}, {56'd0, d3}, 8, 3, 1'b0, 3, c);
    m2 = model_next(m2, s5, d5, 16, 5, 1'b1, 255, c);
    q0.push_back(m0);
    q1.push_back(m1);
    q2.push_back(m2);
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_u0_out"}, 32'(o0), 32'd0); chk({tag, "_u0_valid"}, 32'(v0), 32'd0);
    chk({tag, "_u0_idx"}, 32'(i0), 32'd0); chk({tag, "_u0_err"}, 32'(e0), 32'd0);
    chk({tag, "_u0_cnt"}, 32'(c0), 32'd0);
    chk({tag, "_u1_out"}, 32'(o1), 32'd0); chk({tag, "_u1_valid"}, 32'(v1), 32'd0);
    chk({tag, "_u1_idx"}, 32'(i1), 32'd0); chk({tag, "_u1_err"}, 32'(e1), 32'd0);
    chk({tag, "_u1_cnt"}, 32'(c1), 32'd0);
    chk({tag, "_u2_out"}, 32'(o2), 32'd0); chk({tag, "_u2_valid"}, 32'(v2), 32'd0);
    chk({tag, "_u2_idx"}, 32'(i2), 32'd0); chk({tag, "_u2_err"}, 32'(e2), 32'd0);
    chk({tag, "_u2_cnt"}, 32'(c2), 32'd0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    rst = 1'b1; sel3 = 3'd0; sel5 = 5'd0; clr_err = 1'b0;
    #1;
    check_zero("mid_rst");
    m0 = '0; m1 = '0; m2 = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [79:0] rnd80();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  initial begin
    rst = 1'b1; clr_err = 1'b0;
    sel3 = 3'd0; data3 = 24'd0; sel5 = 5'd0; data5 = 80'd0;
    m0 = '0; m1 = '0; m2 = '0;
    #3;
    check_zero("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Saturating counter on the CNT_W=2 instance: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      step(3'b001, 24'($urandom), 5'd0, rnd80(), 1'b0);
      chk("sat_cnt", 32'(c1), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // Hold after a single capture; wide instance captures channel 4 alongside
    step(3'b010, {8'h00, 8'hA5, 8'h00}, 5'b10000, {16'hA5A5, 64'd0}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 24'($urandom), 5'd0, rnd80(), 1'b0);
      chk("hold_out", 32'(o0), 32'hA5);
      chk("hold_idx", 32'(i0), 32'd1);
      chk("hold_valid", 32'(v0), 32'd1);
      chk("wide_out", 32'(o2), 32'hA5A5);
      chk("wide_idx", 32'(i2), 32'd4);
      chk("wide_valid", 32'(v2), 32'd1);
    end

    // Clear-on-idle instance
    step(3'b100, {8'h3C, 16'h0000}, 5'd0, rnd80(), 1'b0);
    chk("clr_cap_out", 32'(o1), 32'h3C);
    step(3'b000, 24'($urandom), 5'd0, rnd80(), 1'b0);
    chk("clr_idle_out", 32'(o1), 32'h00);
    chk("clr_idle_valid", 32'(v1), 32'd0);
    chk("clr_idle_idx", 32'(i1), 32'd2);

    // Multi-select sets the sticky flag; clear with idle select
    step(3'b110, {8'h22, 8'h11, 8'h00}, 5'd0, rnd80(), 1'b0);
    chk("multi_out", 32'(o0), 32'h11);
    chk("multi_idx", 32'(i0), 32'd1);
    chk("multi_err", 32'(e0), 32'd1);
    step(3'b000, 24'($urandom), 5'd0, rnd80(), 1'b1);
    chk("clr_err_idle", 32'(e0), 32'd0);

    // Set beats clear on the same edge
    step(3'b011, {8'h00, 8'h77, 8'h5A}, 5'd0, rnd80(), 1'b1);
    chk("set_wins_err", 32'(e0), 32'd1);
    chk("set_wins_out", 32'(o0), 32'h5A);
    step(3'b001, 24'($urandom), 5'd0, rnd80(), 1'b1);
    chk("clr_err_single", 32'(e0), 32'd0);

    // Mid-operation reset after captures and a multi-select
    step(3'b111, 24'($urandom), 5'b00110, rnd80(), 1'b0);
    do_reset();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        logic [2:0] s3;
        logic [4:0] s5;
        s3 = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
        s5 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        step(s3, 24'($urandom), s5, rnd80(), 1'($urandom_range(0, 3) == 0));
      end
    end

    chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
